// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round helper functions
// for the preimage searcher and its round datapath.
package sha1_pkg;

  localparam logic [31:0] Iv0 = 32'h67452301;
  localparam logic [31:0] Iv1 = 32'hEFCDAB89;
  localparam logic [31:0] Iv2 = 32'h98BADCFE;
  localparam logic [31:0] Iv3 = 32'h10325476;
  localparam logic [31:0] Iv4 = 32'hC3D2E1F0;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StCheck,
    StDone
  } state_e;

  function automatic logic [31:0] sha1_rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20) begin
      return (b & c) | (~b & d);
    end else if (t < 7'd40) begin
      return b ^ c ^ d;
    end else if (t < 7'd60) begin
      return (b & c) | (b & d) | (c & d);
    end
    return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    if (t < 7'd20) begin
      return K0;
    end else if (t < 7'd40) begin
      return K1;
    end else if (t < 7'd60) begin
      return K2;
    end
    return K3;
  endfunction

  // Single-block padding: message in the top msg_bits, then a 1, zeros, 64-bit length.
  function automatic logic [511:0] sha1_pad(input logic [31:0] m, input int unsigned msg_bits);
    logic [511:0] blk;
    logic [8:0]   pos;
    blk            = '0;
    blk[511:480]   = m << (32 - msg_bits);
    pos            = 9'(511 - msg_bits);
    blk[pos]       = 1'b1;
    blk[63:0]      = 64'(msg_bits);
    return blk;
  endfunction

endpackage

// File: rtl/sha1_round_step.sv
// Combinational SHA-1 round: one compression step for round index t.
module sha1_round_step
  import sha1_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] w,
  input  logic [6:0]  t,
  output logic [31:0] a_nxt,
  output logic [31:0] b_nxt,
  output logic [31:0] c_nxt,
  output logic [31:0] d_nxt,
  output logic [31:0] e_nxt
);

  always_comb begin
    a_nxt = sha1_rotl(a, 5) + sha1_f(t, b, c, d) + e + sha1_k(t) + w;
    b_nxt = a;
    c_nxt = sha1_rotl(b, 30);
    d_nxt = c;
    e_nxt = d;
  end

endmodule

// File: rtl/sha1_preimage_search.sv
// Sequential SHA-1 preimage searcher, one round per clock over all MSG_BITS-bit candidates.
// Define SHA1_SEARCH_COUNT_EN to scan the whole space and report match_count.
module sha1_preimage_search
  import sha1_pkg::*;
#(
  parameter int unsigned MSG_BITS    = 10,
  parameter int unsigned TARGET_BITS = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [159:0]        target,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [MSG_BITS-1:0] preimage,
`ifdef SHA1_SEARCH_COUNT_EN
  output logic [MSG_BITS:0]   match_count,
`endif
  output logic [159:0]        digest
);

  localparam logic [6:0]          LastRound = 7'd79;
  localparam logic [MSG_BITS-1:0] LastCand  = '1;
  localparam logic [MSG_BITS-1:0] CandOne   = MSG_BITS'(1);

  state_e                   state_q, state_d;
  logic [MSG_BITS-1:0]      cand_q, cand_d;
  logic [6:0]               round_q, round_d;
  logic [TARGET_BITS-1:0]   tgt_q, tgt_d;
  logic [31:0]              a_q, b_q, c_q, d_q, e_q;
  logic [31:0]              a_d, b_d, c_d, d_d, e_d;
  logic [31:0]              a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;
  // w_q[15] holds W[t]; w_q[0] holds W[t+15].
  logic [15:0][31:0]        w_q, w_d;
  logic [31:0]              w_new;
  logic                     busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [MSG_BITS-1:0]      pre_q, pre_d;
  logic [159:0]             dig_q, dig_d, sum;
  logic                     match;
  logic                     unused_target;
`ifdef SHA1_SEARCH_COUNT_EN
  localparam logic [MSG_BITS:0] CountOne = (MSG_BITS + 1)'(1);
  logic [MSG_BITS:0]        count_q, count_d;
`endif

  assign unused_target = ^target;

  sha1_round_step u_round (
    .a     (a_q),
    .b     (b_q),
    .c     (c_q),
    .d     (d_q),
    .e     (e_q),
    .w     (w_q[15]),
    .t     (round_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .c_nxt (c_nxt),
    .d_nxt (d_nxt),
    .e_nxt (e_nxt)
  );

  assign w_new = sha1_rotl(w_q[2] ^ w_q[7] ^ w_q[13] ^ w_q[15], 1);
  assign sum   = {a_q + Iv0, b_q + Iv1, c_q + Iv2, d_q + Iv3, e_q + Iv4};
  assign match = (sum[159 -: TARGET_BITS] == tgt_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    round_d = round_q;
    tgt_d   = tgt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    w_d     = w_q;
    busy_d  = (state_q == StLoad) || (state_q == StRound) || (state_q == StCheck);
    done_d  = done_q;
    found_d = found_q;
    pre_d   = pre_q;
    dig_d   = dig_q;
`ifdef SHA1_SEARCH_COUNT_EN
    count_d = count_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        done_d = (state_q == StDone);
        if (start) begin
          tgt_d   = target[159 -: TARGET_BITS];
          cand_d  = '0;
          done_d  = 1'b0;
          found_d = 1'b0;
`ifdef SHA1_SEARCH_COUNT_EN
          count_d = '0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        a_d     = Iv0;
        b_d     = Iv1;
        c_d     = Iv2;
        d_d     = Iv3;
        e_d     = Iv4;
        w_d     = sha1_pad(32'(cand_q), MSG_BITS);
        round_d = '0;
        state_d = StRound;
      end
      StRound: begin
        a_d     = a_nxt;
        b_d     = b_nxt;
        c_d     = c_nxt;
        d_d     = d_nxt;
        e_d     = e_nxt;
        w_d     = {w_q[14:0], w_new};
        round_d = round_q + 7'd1;
        if (round_q == LastRound) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
`ifdef SHA1_SEARCH_COUNT_EN
        if (match) begin
          if (count_q == '0) begin
            pre_d = cand_q;
            dig_d = sum;
          end
          count_d = count_q + CountOne;
          found_d = 1'b1;
        end
        if (cand_q == LastCand) begin
          state_d = StDone;
        end else begin
          cand_d  = cand_q + CandOne;
          state_d = StLoad;
        end
`else
        if (match) begin
          found_d = 1'b1;
          pre_d   = cand_q;
          dig_d   = sum;
          state_d = StDone;
        end else if (cand_q == LastCand) begin
          found_d = 1'b0;
          state_d = StDone;
        end else begin
          cand_d  = cand_q + CandOne;
          state_d = StLoad;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a coincident start.
    if (abort) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      found_d = 1'b0;
`ifdef SHA1_SEARCH_COUNT_EN
      count_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= '0;
      round_q <= '0;
      tgt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      pre_q   <= '0;
      dig_q   <= '0;
`ifdef SHA1_SEARCH_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      round_q <= round_d;
      tgt_q   <= tgt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
`ifdef SHA1_SEARCH_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign preimage = pre_q;
  assign digest   = dig_q;
`ifdef SHA1_SEARCH_COUNT_EN
  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_sha1_preimage_search.sv
// Directed bench for sha1_preimage_search against an array-based SHA-1 model.
module tb_sha1_preimage_search;

`ifdef SHA1_SEARCH_COUNT_EN
  localparam int unsigned MB = 6;
`else
  localparam int unsigned MB = 8;
`endif
  localparam int unsigned TB     = 24;
  localparam int          NCand  = 1 << MB;
  localparam int          FullLat = 1 + 82 * NCand;
  localparam int          MaxLat = FullLat + 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [159:0]  target;
  logic          busy;
  logic          done;
  logic          found;
  logic [MB-1:0] preimage;
  logic [159:0]  digest;
`ifdef SHA1_SEARCH_COUNT_EN
  logic [MB:0]   match_count;
`endif

  always #5 clk = ~clk;

  sha1_preimage_search #(
    .MSG_BITS    (MB),
    .TARGET_BITS (TB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .preimage    (preimage),
`ifdef SHA1_SEARCH_COUNT_EN
    .match_count (match_count),
`endif
    .digest      (digest)
  );

  int checks   = 0;
  int failures = 0;

  logic [159:0] dig_tab [NCand];

  typedef struct {
    logic [159:0] tgt;
    bit           exp_found;
    int           exp_pre;
    int           exp_lat;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [159:0] model_sha1(input logic [31:0] m);
    logic [511:0] blk;
    logic [31:0]  w [80];
    logic [31:0]  a, b, c, d, e, f, k, tmp;
    blk = '0;
    blk[511 -: MB] = m[MB-1:0];
    blk[511 - MB]  = 1'b1;
    blk[63:0]      = 64'(MB);
    for (int t = 0; t < 16; t++) begin
      w[t] = blk[511:480];
      blk  = blk << 32;
    end
    for (int t = 16; t < 80; t++) begin
      tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int t = 0; t < 80; t++) begin
      if (t < 20) begin
        f = (b & c) | (~b & d); k = 32'h5A827999;
      end else if (t < 40) begin
        f = b ^ c ^ d; k = 32'h6ED9EBA1;
      end else if (t < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d; k = 32'hCA62C1D6;
      end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
            d + 32'h10325476, e + 32'hC3D2E1F0};
  endfunction

  function automatic int lowest_match(input logic [159:0] tgt);
    for (int i = 0; i < NCand; i++) begin
      if (dig_tab[i][159 -: TB] == tgt[159 -: TB]) return i;
    end
    return -1;
  endfunction

  function automatic int count_matches(input logic [159:0] tgt);
    int n = 0;
    for (int i = 0; i < NCand; i++) begin
      if (dig_tab[i][159 -: TB] == tgt[159 -: TB]) n++;
    end
    return n;
  endfunction

  function automatic int expected_latency(input int pre);
`ifdef SHA1_SEARCH_COUNT_EN
    return FullLat;
`else
    if (pre < 0) return FullLat;
    return 1 + 82 * (pre + 1);
`endif
  endfunction

  function automatic vec_t make_vec(input logic [159:0] tgt);
    vec_t v;
    v.tgt       = tgt;
    v.exp_pre   = lowest_match(tgt);
    v.exp_found = (v.exp_pre >= 0);
    v.exp_lat   = expected_latency(v.exp_pre);
    return v;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Start a search and count edges until done; optionally pulse a stray start while busy.
  task automatic do_search(input logic [159:0] tgt, input bit noise, output int lat);
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    target = ~tgt;
    lat    = 0;
    for (int e = 1; e <= MaxLat; e++) begin
      if (noise && e == 10) start = 1'b1;
      if (noise && e == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (e == 1) check("busy_after_start", 160'(busy), 160'(1'b1));
      if (done) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    check({tag, ".latency"}, 160'(lat), 160'(v.exp_lat));
    check({tag, ".found"}, 160'(found), 160'(v.exp_found));
    check({tag, ".busy_at_done"}, 160'(busy), 160'(1'b0));
    if (v.exp_found) begin
      check({tag, ".preimage"}, 160'(preimage), 160'(v.exp_pre));
      check({tag, ".digest"}, digest, dig_tab[v.exp_pre]);
    end
`ifdef SHA1_SEARCH_COUNT_EN
    check({tag, ".match_count"}, 160'(match_count), 160'(count_matches(v.tgt)));
`endif
  endtask

  initial begin
    int           lat;
    logic [159:0] unreach;
    vec_t         va;

    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;

    for (int i = 0; i < NCand; i++) dig_tab[i] = model_sha1(32'(i));

    unreach = '1;
    while (lowest_match(unreach) >= 0) unreach[159 -: TB] = unreach[159 -: TB] - TB'(1);

    vecs[0] = make_vec(dig_tab[0]);
    vecs[1] = make_vec(dig_tab[165 % NCand]);
    vecs[2] = make_vec({dig_tab[19][159 -: TB], ~dig_tab[19][159-TB:0]});
    vecs[3] = make_vec(unreach);

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 160'(busy), 160'(1'b0));
    check("reset.done", 160'(done), 160'(1'b0));
    check("reset.found", 160'(found), 160'(1'b0));
    check("reset.preimage", 160'(preimage), 160'(0));
    check("reset.digest", digest, 160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_search(vecs[i].tgt, 1'b0, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
    end

    // Reset held for three cycles in the middle of the round loop.
    @(negedge clk);
    target = vecs[1].tgt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset.busy", 160'(busy), 160'(1'b0));
    check("midreset.done", 160'(done), 160'(1'b0));
    check("midreset.found", 160'(found), 160'(1'b0));
    check("midreset.preimage", 160'(preimage), 160'(0));
    check("midreset.digest", digest, 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_search(vecs[0].tgt, 1'b0, lat);
    check_result("after_reset", vecs[0], lat);

    // Abort after 500 cycles, then abort+start together, then a clean rerun.
    va = make_vec(dig_tab[12]);
    @(negedge clk);
    target = va.tgt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort.busy", 160'(busy), 160'(1'b0));
    check("abort.done", 160'(done), 160'(1'b0));
    check("abort.found", 160'(found), 160'(1'b0));
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    check("abort_start.busy", 160'(busy), 160'(1'b0));
    do_search(va.tgt, 1'b0, lat);
    check_result("rerun", va, lat);

    // A start pulse with a different target while busy must be ignored.
    do_search(vecs[2].tgt, 1'b1, lat);
    check_result("start_while_busy", vecs[2], lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
